cam_dvp_tx: RTL

Parallel-camera (DVP, OV7670-style) transmitter that drives PCLK, VSYNC, HREF and 8-bit RGB565 bytes from a pixel stream. It is the source-side counterpart of the camera capture path. It serves as a sensor emulator for bench and loopback testing of the capture/line-buffer/VGA chain, and as a DVP output for downstream boards. Frame geometry is set by parameters; pixels are pulled with a ready/valid handshake.

---
 rtl/cam_dvp_pkg.sv | 26 ++
 rtl/cam_dvp_timing.sv | 76 +++++++
 rtl/cam_dvp_tx.sv | 68 ++++++
 3 files changed

// File: rtl/cam_dvp_pkg.sv
// cam_dvp_pkg: shared FSM states, counter widths and RGB565 colour-bar values for the DVP transmitter
package cam_dvp_pkg;
   localparam int BYTE_W = 11;
   localparam int LINE_W = 10;
   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} dvpState_t;
   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;
   function automatic logic [15:0] barColor(input logic [2:0] band);
      case (band)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction
endpackage

// File: rtl/cam_dvp_timing.sv
// cam_dvp_timing: PCLK phase, byte/line counters, frame FSM and registered VSYNC/HREF (pixel index port with CAM_DVP_TPG_EN)
module cam_dvp_timing
   import cam_dvp_pkg::*;
#(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 144,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ENABLE,
   output logic              ph,
   output logic              CamVsync,
   output logic              CamHsync,
   output logic              FRAME_START,
`ifdef CAM_DVP_TPG_EN
   output logic [BYTE_W-2:0] pixNext,
`endif
   output logic              hrefNext,
   output logic              pullNext
);
   localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(2 * (H_ACTIVE + H_BLANK) - 1);
   localparam logic [BYTE_W-1:0] HREF_BYTES = BYTE_W'(2 * H_ACTIVE);
   dvpState_t state, stateNext;
   logic [BYTE_W-1:0] byteCnt, byteNext;
   logic [LINE_W-1:0] lineCnt, lineNext, lastLine;
   logic endLine, endState;
`ifdef CAM_DVP_TPG_EN
   assign pixNext = byteNext[BYTE_W-1:1];
`endif
   // values the counters, state and HREF take at the coming byte boundary
   always_comb begin
      lastLine = state == VSYNC ? LINE_W'(VSYNC_LINES - 1) : state == VBACK ? LINE_W'(V_BACK - 1) :
                 state == ACTIVE ? LINE_W'(V_ACTIVE - 1) : LINE_W'(V_FRONT - 1);
      endLine = state != IDLE && byteCnt == LAST_BYTE;
      endState = endLine && lineCnt == lastLine;
      byteNext = (endLine || state == IDLE) ? '0 : byteCnt + BYTE_W'(1);
      lineNext = (endState || state == IDLE) ? '0 : lineCnt + LINE_W'(endLine);
      stateNext = state;
      case (state)
         IDLE:    stateNext = ENABLE ? VSYNC : IDLE;
         VSYNC:   if (endState) stateNext = VBACK;
         VBACK:   if (endState) stateNext = ACTIVE;
         ACTIVE:  if (endState) stateNext = VFRONT;
         VFRONT:  if (endState) stateNext = ENABLE ? VSYNC : IDLE;
         default: stateNext = IDLE;
      endcase
      hrefNext = stateNext == ACTIVE && byteNext < HREF_BYTES;
      pullNext = hrefNext && !byteNext[0];
   end
   // phase toggles every CLK; everything else moves only on byte boundaries (ph==1, PCLK falling)
   always_ff @(posedge CLK) begin
      if (RST) begin
         ph          <= 1'b0;
         state       <= IDLE;
         byteCnt     <= '0;
         lineCnt     <= '0;
         CamVsync    <= 1'b0;
         CamHsync    <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         ph          <= !ph;
         FRAME_START <= ph && stateNext == VSYNC && state != VSYNC;
         if (ph) begin
            state    <= stateNext;
            byteCnt  <= byteNext;
            lineCnt  <= lineNext;
            CamVsync <= stateNext == VSYNC;
            CamHsync <= hrefNext;
         end
      end
   end
endmodule

// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx: DVP (OV7670-style) RGB565 transmitter; define CAM_DVP_TPG_EN to add TPG_SEL and the colour-bar source
module cam_dvp_tx
   import cam_dvp_pkg::*;
#(
   parameter int          H_ACTIVE    = 640,
   parameter int          H_BLANK     = 144,
   parameter int          V_ACTIVE    = 480,
   parameter int          VSYNC_LINES = 3,
   parameter int          V_BACK      = 17,
   parameter int          V_FRONT     = 10,
   parameter logic [15:0] FILL_COLOR  = 16'hF800
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ENABLE,
`ifdef CAM_DVP_TPG_EN
   input  logic        TPG_SEL,
`endif
   input  logic [15:0] PIX_DATA,
   input  logic        PIX_VALID,
   output logic        PIX_READY,
   output logic        PCLK,
   output logic        CamVsync,
   output logic        CamHsync,
   output logic [7:0]  CamData,
   output logic        FRAME_START,
   output logic        UNDERFLOW
);
   logic ph, hrefNext, pullNext, streamOn;
   logic [15:0] pix;
   logic [7:0] loReg;
`ifdef CAM_DVP_TPG_EN
   logic [BYTE_W-2:0] pixNext;
   assign streamOn = !TPG_SEL;
   assign pix = TPG_SEL ? barColor(3'((32'(pixNext) * 8) / H_ACTIVE)) : PIX_VALID ? PIX_DATA : FILL_COLOR;
`else
   assign streamOn = 1'b1;
   assign pix = PIX_VALID ? PIX_DATA : FILL_COLOR;
`endif
   assign PCLK = ph;
   cam_dvp_timing #(
      .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
      .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
   ) uTiming (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .ph(ph),
      .CamVsync(CamVsync), .CamHsync(CamHsync), .FRAME_START(FRAME_START),
`ifdef CAM_DVP_TPG_EN
      .pixNext(pixNext),
`endif
      .hrefNext(hrefNext), .pullNext(pullNext)
   );
   // ready is raised the CLK before the boundary that consumes the pixel; high byte goes out first, low byte is held for the next boundary
   always_ff @(posedge CLK) begin
      if (RST) begin
         PIX_READY <= 1'b0;
         CamData   <= '0;
         loReg     <= '0;
         UNDERFLOW <= 1'b0;
      end else begin
         PIX_READY <= !ph && pullNext && streamOn;
         if (ph) begin
            CamData <= !hrefNext ? 8'h00 : pullNext ? pix[15:8] : loReg;
            if (pullNext) loReg <= pix[7:0];
         end
         if (ph && pullNext && streamOn && !PIX_VALID) UNDERFLOW <= 1'b1;
      end
   end
endmodule
